sync_down_counter: RTL and testbench

Parameterised synchronous down-counter/timer that is the counting-direction complement to the team's 4-bit up counter. It loads a start value, decrements on each enabled clock, and signals terminal count, optionally auto-reloading for periodic operation. It sits beside the up counter in the counter library as the timeout/period generator for control blocks.

---
 rtl/sync_down_counter_if.sv | 24 ++
 rtl/sync_down_counter.sv | 132 +++++++++++++
 tb/tb_sync_down_counter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/sync_down_counter_if.sv
// Handshake bundle for sync_down_counter: load/enable controls in, count and
// status flags out. WIDTH must match the counter instance it connects to.
interface sync_down_counter_if #(
  parameter int WIDTH = 4
) ();
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             auto_reload;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             busy;
  logic             done;

  modport master (
    output load, load_val, en, auto_reload,
    input  count, tc, busy, done
  );

  modport slave (
    input  load, load_val, en, auto_reload,
    output count, tc, busy, done
  );
endinterface

// File: rtl/sync_down_counter.sv
// Loadable down-counter/timer with terminal-count pulse and optional auto-reload.
// Checker module first, then the counter top that instantiates it.
module sync_down_counter_chk #(
  parameter int WIDTH = 4
) (
  input logic             clk,
  input logic             clr,
  input logic [WIDTH-1:0] count,
  input logic             tc,
  input logic             busy,
  input logic             done
);
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

  a_busy_done_excl: assert property (@(posedge clk) disable iff (clr)
    !(busy && done));

  a_run_nonzero: assert property (@(posedge clk) disable iff (clr)
    busy |-> (count != ZERO));

  a_done_zero: assert property (@(posedge clk) disable iff (clr)
    done |-> (count == ZERO));

  a_clr_effect: assert property (@(posedge clk)
    clr |=> ((count == ZERO) && !tc && !busy && !done));
endmodule

module sync_down_counter #(
  parameter int WIDTH = 4
) (
  input logic                clk,
  input logic                clr,
  sync_down_counter_if.slave bus
);
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] count_s;
  logic [WIDTH-1:0] rld_r;
  logic [WIDTH-1:0] rld_s;
  logic             tc_r;
  logic             tc_s;
  logic             busy_r;
  logic             done_r;

  // Next-state and next-output logic; load outranks any count step.
  always_comb begin
    state_s = state_r;
    count_s = count_r;
    rld_s   = rld_r;
    tc_s    = 1'b0;
    if (bus.load) begin
      count_s = bus.load_val;
      rld_s   = bus.load_val;
      if (bus.load_val != ZERO) begin
        state_s = ST_RUN;
      end else begin
        state_s = ST_IDLE;
      end
    end else begin
      case (state_r)
        ST_RUN: begin
          if (!bus.en) begin
            count_s = count_r;
          end else if (count_r == ONE) begin
            tc_s = 1'b1;
            if (bus.auto_reload) begin
              count_s = rld_r;
            end else begin
              count_s = ZERO;
              state_s = ST_DONE;
            end
          end else if (count_r == ZERO) begin
            // Unreachable in normal operation; park safely rather than wrap.
            state_s = ST_IDLE;
          end else begin
            count_s = count_r - ONE;
          end
        end
        ST_IDLE, ST_DONE: begin
          state_s = state_r;
        end
        default: begin
          state_s = ST_IDLE;
          count_s = ZERO;
        end
      endcase
    end
  end

  // State and output registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r <= ST_IDLE;
      count_r <= ZERO;
      rld_r   <= ZERO;
      tc_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      count_r <= count_s;
      rld_r   <= rld_s;
      tc_r    <= tc_s;
      busy_r  <= (state_s == ST_RUN);
      done_r  <= (state_s == ST_DONE);
    end
  end

  assign bus.count = count_r;
  assign bus.tc    = tc_r;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;

  sync_down_counter_chk #(.WIDTH(WIDTH)) u_chk (
    .clk   (clk),
    .clr   (clr),
    .count (count_r),
    .tc    (tc_r),
    .busy  (busy_r),
    .done  (done_r)
  );
endmodule

// File: tb/tb_sync_down_counter.sv
// Directed, table-driven bench for sync_down_counter at WIDTH=4, followed by a
// hand-written one-shot sequence that checks terminal timing and the DONE hold.
module tb_sync_down_counter;
  logic clk;
  logic clr;
  int   checks;
  int   errors;

  sync_down_counter_if #(.WIDTH(4)) bus ();

  sync_down_counter #(.WIDTH(4)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    logic       load;
    logic [3:0] load_val;
    logic       en;
    logic       ar;
    logic [3:0] ec;
    logic       etc;
    logic       eb;
    logic       ed;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic c, input logic l, input logic [3:0] lv,
                     input logic e, input logic ar, input logic [3:0] ec,
                     input logic etc, input logic eb, input logic ed);
    vec_t v;
    v.clr = c; v.load = l; v.load_val = lv; v.en = e; v.ar = ar;
    v.ec = ec; v.etc = etc; v.eb = eb; v.ed = ed;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic c, input logic l, input logic [3:0] lv,
                       input logic e, input logic ar);
    clr             = c;
    bus.load        = l;
    bus.load_val    = lv;
    bus.en          = e;
    bus.auto_reload = ar;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] ec, input logic etc,
                       input logic eb, input logic ed);
    checks++;
    if (bus.count !== ec || bus.tc !== etc || bus.busy !== eb || bus.done !== ed) begin
      errors++;
      $display("FAIL %s count/tc/busy/done got %0d/%b/%b/%b want %0d/%b/%b/%b",
               name, bus.count, bus.tc, bus.busy, bus.done, ec, etc, eb, ed);
    end
  endtask

  initial begin
    int cyc;
    int pulses;
    bit seen_tc;
    checks = 0;
    errors = 0;
    clr = 1'b1;
    bus.load = 1'b0;
    bus.load_val = 4'd0;
    bus.en = 1'b0;
    bus.auto_reload = 1'b0;

    // Reset, then idle with en ignored
    add(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    // One-shot from 5
    add(1'b0, 1'b1, 4'd5, 1'b1, 1'b0, 4'd5, 1'b0, 1'b1, 1'b0);
    for (int k = 4; k >= 1; k--)
      add(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'(k), 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
    add(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    // Auto-reload period 3, 12 enabled cycles, 4 pulses
    add(1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 4'd3, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      if (i % 3 == 0)      add(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd2, 1'b0, 1'b1, 1'b0);
      else if (i % 3 == 1) add(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd1, 1'b0, 1'b1, 1'b0);
      else                 add(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0);
    end
    // Load 4 with en toggling
    add(1'b0, 1'b1, 4'd4, 1'b0, 1'b0, 4'd4, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
    // Load colliding with terminal count, then load of zero
    add(1'b0, 1'b1, 4'd2, 1'b1, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 4'd9, 1'b1, 1'b0, 4'd9, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd8, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    // Clear mid-count beats load/en, then a fresh load of 2
    add(1'b0, 1'b1, 4'd15, 1'b1, 1'b0, 4'd15, 1'b0, 1'b1, 1'b0);
    for (int k = 14; k >= 7; k--)
      add(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'(k), 1'b0, 1'b1, 1'b0);
    add(1'b1, 1'b1, 4'd9, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 4'd2, 1'b1, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
    // Reload value 1: tc on every enabled cycle
    add(1'b0, 1'b1, 4'd1, 1'b1, 1'b1, 4'd1, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd1, 1'b1, 1'b1, 1'b0);
    add(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd1, 1'b1, 1'b1, 1'b0);
    add(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b1, 1'b0);
    // auto_reload only matters on the terminal cycle
    add(1'b0, 1'b1, 4'd2, 1'b1, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd2, 1'b1, 1'b1, 1'b0);
    add(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1);

    foreach (vecs[i]) begin
      drive(vecs[i].clr, vecs[i].load, vecs[i].load_val, vecs[i].en, vecs[i].ar);
      check($sformatf("vec%0d", i), vecs[i].ec, vecs[i].etc, vecs[i].eb, vecs[i].ed);
    end

    // One-shot of 6: tc must land after exactly 6 enabled cycles
    drive(1'b0, 1'b1, 4'd6, 1'b1, 1'b0);
    check("load6", 4'd6, 1'b0, 1'b1, 1'b0);
    cyc = 0;
    pulses = 0;
    seen_tc = 1'b0;
    while (!seen_tc && cyc < 20) begin
      drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
      cyc++;
      if (bus.tc === 1'b1) begin
        seen_tc = 1'b1;
        pulses++;
      end
    end
    checks++;
    if (cyc != 6 || !seen_tc) begin
      errors++;
      $display("FAIL period6 got %0d cycles (tc seen %0b) want 6", cyc, seen_tc);
    end
    check("term6", 4'd0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
      if (bus.tc === 1'b1) pulses++;
      check($sformatf("hold%0d", i), 4'd0, 1'b0, 1'b0, 1'b1);
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL tc_pulses got %0d want 1", pulses);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
